// File: rtl/regn_univ.sv
// regn_univ: N-bit universal register.
// Single-cycle ops: hold, parallel load, shift left/right, rotate left/right,
// arithmetic shift right. Multi-cycle burst rotate-right by Amt positions,
// sequenced by a two-state FSM with a Busy/Done handshake.
// Optional feature macro: REGN_UNIV_PARITY_EN -- when defined, Par is a
// registered even-parity bit of Q; when undefined, Par is tied to 0.
module regn_univ #(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 3
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          En,
    input  logic [2:0]    Mode,
    input  logic [N-1:0]  R,
    input  logic [AW-1:0] Amt,
    input  logic          SinL,
    input  logic          SinR,
    output logic [N-1:0]  Q,
    output logic          Busy,
    output logic          Done,
    output logic          Par
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL1  = 3'b010;
    localparam logic [2:0] MODE_SHR1  = 3'b011;
    localparam logic [2:0] MODE_ROTL1 = 3'b100;
    localparam logic [2:0] MODE_ROTR1 = 3'b101;
    localparam logic [2:0] MODE_ASR1  = 3'b110;
    localparam logic [2:0] MODE_BURST = 3'b111;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic [N-1:0]  q_q,     q_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    // State register and datapath flops; reset aborts any burst in progress
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, next-Q and handshake decode; Busy/Done default low
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (En) begin
                    case (Mode)
                        MODE_LOAD:  q_d = R;
                        MODE_SHL1:  q_d = {q_q[N-2:0], SinL};
                        MODE_SHR1:  q_d = {SinR, q_q[N-1:1]};
                        MODE_ROTL1: q_d = {q_q[N-2:0], q_q[N-1]};
                        MODE_ROTR1: q_d = {q_q[0], q_q[N-1:1]};
                        MODE_ASR1:  q_d = {q_q[N-1], q_q[N-1:1]};
                        MODE_BURST: begin
                            // A zero-length burst completes immediately
                            if (Amt == AW'(0)) begin
                                done_d = 1'b1;
                            end else begin
                                cnt_d   = Amt;
                                state_d = ST_BURST;
                                busy_d  = 1'b1;
                            end
                        end
                        default:    q_d = q_q;
                    endcase
                end
            end

            ST_BURST: begin
                // All command inputs are ignored while the burst runs
                q_d   = {q_q[0], q_q[N-1:1]};
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Q    = q_q;
    assign Busy = busy_q;
    assign Done = done_q;

`ifdef REGN_UNIV_PARITY_EN
    logic par_q;
    logic par_d;

    // Parity of the value Q is about to take, so Par tracks Q cycle for cycle
    always_comb begin
        par_d = ^q_d;
    end

    // Parity flop
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign Par = par_q;
`else
    assign Par = 1'b0;
`endif

endmodule

// File: tb/tb_regn_univ.sv
// Self-checking bench for regn_univ (N=8, AW=3): directed vector table,
// hand-written burst/abort sequences, and randomized stimulus against a model.
module tb_regn_univ;

    localparam int unsigned N  = 8;
    localparam int unsigned AW = 3;

    logic          Clock;
    logic          Reset;
    logic          En;
    logic [2:0]    Mode;
    logic [N-1:0]  R;
    logic [AW-1:0] Amt;
    logic          SinL;
    logic          SinR;
    logic [N-1:0]  Q;
    logic          Busy;
    logic          Done;
    logic          Par;

    int n_cmp = 0;
    int n_err = 0;

    regn_univ #(.N(N), .AW(AW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .En    (En),
        .Mode  (Mode),
        .R     (R),
        .Amt   (Amt),
        .SinL  (SinL),
        .SinR  (SinR),
        .Q     (Q),
        .Busy  (Busy),
        .Done  (Done),
        .Par   (Par)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [7:0] r;
        logic       sinl;
        logic       sinr;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[14];

    // Rotate right by k positions, computed arithmetically
    function automatic logic [7:0] rot_r(input logic [7:0] v, input int k);
        int kk;
        kk = k % 8;
        if (kk == 0) return v;
        return (v >> kk) | (v << (8 - kk));
    endfunction

    function automatic logic exp_parity(input logic [7:0] v);
`ifdef REGN_UNIV_PARITY_EN
        return ^v;
`else
        return 1'b0 & v[0];
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] eq, input logic eb, input logic ed);
        check({name, ".Q"},    32'(Q),    32'(eq));
        check({name, ".Busy"}, 32'(Busy), 32'(eb));
        check({name, ".Done"}, 32'(Done), 32'(ed));
        check({name, ".Par"},  32'(Par),  32'(exp_parity(eq)));
    endtask

    // Drive inputs at the falling edge, return 1 time unit after the rising edge
    task automatic step(input logic en, input logic [2:0] mode, input logic [7:0] r,
                        input logic [2:0] amt, input logic sinl, input logic sinr);
        @(negedge Clock);
        En = en; Mode = mode; R = r; Amt = amt; SinL = sinl; SinR = sinr;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 3'b000, 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] v);
        step(1'b1, 3'b001, v, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Reference model state
    logic [7:0] mq;
    logic       m_busy;
    logic       m_done;
    logic [7:0] m_start;
    int         m_amt;
    int         m_i;

    task automatic model_edge(input logic en, input logic [2:0] mode, input logic [7:0] r,
                              input logic [2:0] amt, input logic sinl, input logic sinr);
        if (m_busy) begin
            m_i++;
            mq = rot_r(m_start, m_i);
            m_done = (m_i == m_amt);
            m_busy = (m_i != m_amt);
        end else begin
            m_done = 1'b0;
            if (en) begin
                case (mode)
                    3'd1: mq = r;
                    3'd2: mq = (mq << 1) | 8'(sinl);
                    3'd3: mq = (mq >> 1) | (8'(sinr) << 7);
                    3'd4: mq = rot_r(mq, 7);
                    3'd5: mq = rot_r(mq, 1);
                    3'd6: mq = (mq >> 1) | (mq & 8'h80);
                    3'd7: begin
                        if (amt == 3'd0) begin
                            m_done = 1'b1;
                        end else begin
                            m_busy  = 1'b1;
                            m_amt   = int'(amt);
                            m_i     = 0;
                            m_start = mq;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        En = 1'b0; Mode = 3'b000; R = '0; Amt = '0; SinL = 1'b0; SinR = 1'b0;

        vecs[0]  = '{1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 8'hA5};
        vecs[1]  = '{1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'h4B};
        vecs[2]  = '{1'b1, 3'b011, 8'hFF, 1'b1, 1'b0, 8'h25};
        vecs[3]  = '{1'b0, 3'b001, 8'hFF, 1'b0, 1'b0, 8'h25};
        vecs[4]  = '{1'b1, 3'b000, 8'hFF, 1'b0, 1'b0, 8'h25};
        vecs[5]  = '{1'b1, 3'b001, 8'h80, 1'b0, 1'b0, 8'h80};
        vecs[6]  = '{1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'hC0};
        vecs[7]  = '{1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81};
        vecs[8]  = '{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h03};
        vecs[9]  = '{1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81};
        vecs[10] = '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'hC0};
        vecs[11] = '{1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 8'hE0};
        vecs[12] = '{1'b1, 3'b001, 8'h07, 1'b0, 1'b0, 8'h07};
        vecs[13] = '{1'b1, 3'b001, 8'h03, 1'b0, 1'b0, 8'h03};

        // Reset state, checked while reset is held
        #1;
        check_all("reset", 8'h00, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check_all("post_reset", 8'h00, 1'b0, 1'b0);

        // Directed single-cycle vectors
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].en, vecs[i].mode, vecs[i].r, 3'd0, vecs[i].sinl, vecs[i].sinr);
            check_all($sformatf("vec%0d", i), vecs[i].exp_q, 1'b0, 1'b0);
        end

        // Burst of 3 from 01, with a load attempt ignored mid-burst
        load(8'h01);
        step(1'b1, 3'b111, 8'h00, 3'd3, 1'b0, 1'b0);
        check_all("burst3_start", 8'h01, 1'b1, 1'b0);
        step(1'b1, 3'b001, 8'hFF, 3'd5, 1'b1, 1'b1);
        check_all("burst3_c1", 8'h80, 1'b1, 1'b0);
        step(1'b1, 3'b111, 8'hFF, 3'd1, 1'b0, 1'b0);
        check_all("burst3_c2", 8'h40, 1'b1, 1'b0);
        idle();
        check_all("burst3_done", 8'h20, 1'b0, 1'b1);
        idle();
        check_all("burst3_after", 8'h20, 1'b0, 1'b0);

        // Zero-length burst
        load(8'h5A);
        step(1'b1, 3'b111, 8'h00, 3'd0, 1'b0, 1'b0);
        check_all("burst0_done", 8'h5A, 1'b0, 1'b1);
        idle();
        check_all("burst0_after", 8'h5A, 1'b0, 1'b0);

        // Burst 7 then burst 1 issued in the Done cycle: full rotation
        load(8'h3C);
        step(1'b1, 3'b111, 8'h00, 3'd7, 1'b0, 1'b0);
        check_all("burst7_start", 8'h3C, 1'b1, 1'b0);
        for (int k = 1; k < 7; k++) begin
            idle();
            check_all($sformatf("burst7_c%0d", k), rot_r(8'h3C, k), 1'b1, 1'b0);
        end
        idle();
        check_all("burst7_done", rot_r(8'h3C, 7), 1'b0, 1'b1);
        step(1'b1, 3'b111, 8'h00, 3'd1, 1'b0, 1'b0);
        check_all("burst1_start", rot_r(8'h3C, 7), 1'b1, 1'b0);
        idle();
        check_all("burst1_done", 8'h3C, 1'b0, 1'b1);

        // Abort a burst with reset in its second Busy cycle
        load(8'h81);
        step(1'b1, 3'b111, 8'h00, 3'd4, 1'b0, 1'b0);
        check_all("abort_start", 8'h81, 1'b1, 1'b0);
        idle();
        check_all("abort_c1", 8'hC0, 1'b1, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        check_all("abort_rst", 8'h00, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle();
            check_all($sformatf("abort_after%0d", k), 8'h00, 1'b0, 1'b0);
        end

        // Randomized stimulus against the reference model
        do_reset();
        mq = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_start = 8'h00; m_amt = 0; m_i = 0;
        for (int c = 0; c < 600; c++) begin
            logic       ren;
            logic [2:0] rmode;
            logic [7:0] rr;
            logic [2:0] ramt;
            logic       rsl;
            logic       rsr;
            ren   = ($urandom_range(0, 3) != 0);
            rmode = 3'($urandom_range(0, 7));
            rr    = 8'($urandom);
            ramt  = 3'($urandom_range(0, 7));
            rsl   = 1'($urandom);
            rsr   = 1'($urandom);
            step(ren, rmode, rr, ramt, rsl, rsr);
            model_edge(ren, rmode, rr, ramt, rsl, rsr);
            check_all($sformatf("rand%0d", c), mq, m_busy, m_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
